ram_stream_reader: RTL

- Read-side sequencer placed directly downstream of dual_port_ram port A.
- On a start command it issues sequential reads from a base address for a given length.
- It absorbs the RAM's 1-cycle registered read latency and emits the bytes on a valid/ready stream with full throughput under backpressure.
- Port B of the RAM stays free for a writer, such as a loader or a UART.

---
 rtl/ram_stream_reader_pkg.sv | 25 ++
 rtl/stream_skid_buffer.sv | 60 ++++++
 rtl/ram_stream_reader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader and its output buffer.
// Width defaults match the dual_port_ram instance that feeds the reader.
package ram_stream_reader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam int         BUF_DEPTH       = 2;
  localparam int         BUF_COUNT_WIDTH = 2;
  localparam logic [1:0] BUF_FULL        = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Slots that will be committed after this cycle: held entries plus the read in flight, less a pop.
  function automatic logic [1:0] occupancy(input logic [1:0] count,
                                           input logic       pending,
                                           input logic       pop);
    return count + {1'b0, pending} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready FIFO; out data/valid come straight from the head entry
// so they hold steady while the consumer stalls.
module stream_skid_buffer
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       ready,
  output logic [DATA_WIDTH-1:0]      data,
  output logic                       valid,
  output logic                       pop,
  output logic [BUF_COUNT_WIDTH-1:0] count
);

  logic [DATA_WIDTH-1:0] entry_r [BUF_DEPTH];
  logic                  rd_ptr_r;
  logic                  wr_ptr_r;
  logic [1:0]            count_r;
  logic                  write_s;

  // Handshake and write-accept decode; a full buffer still accepts when the head leaves.
  always_comb begin
    pop     = (count_r != 2'd0) && ready;
    write_s = push && ((count_r != BUF_FULL) || pop);
  end

  assign valid = (count_r != 2'd0);
  assign data  = entry_r[rd_ptr_r];
  assign count = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        entry_r[i] <= '0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (write_s) begin
        entry_r[wr_ptr_r] <= push_data;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({write_s, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Sequential reader for dual_port_ram port A: issues one read per cycle while
// buffer space allows and streams the returned bytes out on valid/ready.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(1) << ADDR_WIDTH;
  localparam logic [LEN_WIDTH-1:0] ONE_LEN  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] ZERO_LEN = LEN_WIDTH'(0);

  state_t                      state_r;
  state_t                      state_n;
  logic [ADDR_WIDTH-1:0]       addr_r;
  logic [ADDR_WIDTH-1:0]       addr_n;
  logic [LEN_WIDTH-1:0]        remaining_r;
  logic [LEN_WIDTH-1:0]        remaining_n;
  logic                        pending_r;
  logic                        done_r;
  logic                        done_n;
  logic                        issue_s;
  logic                        buf_pop_s;
  logic [BUF_COUNT_WIDTH-1:0]  buf_count_s;
  logic [LEN_WIDTH-1:0]        clamped_len_s;
  logic                        drain_empty_s;

  stream_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buffer (
    .clock    (clock),
    .reset    (reset),
    .push     (pending_r),
    .push_data(ram_data),
    .ready    (out_ready),
    .data     (out_data),
    .valid    (out_valid),
    .pop      (buf_pop_s),
    .count    (buf_count_s)
  );

  assign ram_address      = addr_r;
  assign ram_write_enable = 1'b0;
  assign busy             = (state_r != ST_IDLE);
  assign done             = done_r;

  // Length clamp and the "nothing left in flight" condition used to finish a transfer.
  always_comb begin
    clamped_len_s = (length > MAX_LEN) ? MAX_LEN : length;
    drain_empty_s = !pending_r &&
                    ((buf_count_s == 2'd0) || ((buf_count_s == 2'd1) && buf_pop_s));
  end

  // Next-state, issue and counter logic.
  always_comb begin
    state_n     = state_r;
    addr_n      = addr_r;
    remaining_n = remaining_r;
    done_n      = 1'b0;
    issue_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length == ZERO_LEN) begin
            done_n = 1'b1;
          end else begin
            state_n     = ST_RUN;
            addr_n      = base_addr;
            remaining_n = clamped_len_s;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A read is only issued when its data is guaranteed a buffer slot on return.
        if ((remaining_r != ZERO_LEN) &&
            (occupancy(buf_count_s, pending_r, buf_pop_s) < 2'd2)) begin
          issue_s     = 1'b1;
          addr_n      = addr_r + ADDR_WIDTH'(1);
          remaining_n = remaining_r - ONE_LEN;
          if (remaining_r == ONE_LEN) begin
            state_n = ST_DRAIN;
          end else begin
            state_n = ST_RUN;
          end
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_empty_s) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Control registers; clearing pending on reset discards any read still in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      remaining_r <= '0;
      pending_r   <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      addr_r      <= addr_n;
      remaining_r <= remaining_n;
      pending_r   <= issue_s;
      done_r      <= done_n;
    end
  end

endmodule
